// File: rtl/ram_arb_pkg.sv
// ============================================================================
//  Module   : ram_arb_pkg
//  Purpose  : Shared types and default sizes for the 512x32 RAM port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

  localparam int C_ADDR_W    = 9;
  localparam int C_DATA_W    = 32;
  localparam int C_MAX_BURST = 4;

  // Which port currently holds the RAM.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_e;

  // Port chosen for this cycle's RAM access.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_A    = 2'd1,
    SEL_B    = 2'd2
  } port_sel_e;

  // Ownership state that results from granting a given port.
  function automatic owner_e sel_to_owner(input port_sel_e s);
    owner_e o;
    case (s)
      SEL_A:   o = OWN_A;
      SEL_B:   o = OWN_B;
      default: o = IDLE;
    endcase
    return o;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arb_select.sv
// ============================================================================
//  Module   : ram_arb_select
//  Purpose  : Combinational port selection for the RAM arbiter: burst-limited
//             ownership retention plus the tie-break policy.
//  Config   : ARB_ROUND_ROBIN_EN - ties with no eligible owner go to the port
//             that did not win last; otherwise port A wins ties.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_arb_select
  import ram_arb_pkg::*;
#(
  parameter int MAX_BURST = C_MAX_BURST,
  parameter int CNT_W     = $clog2(MAX_BURST) + 1
) (
  input  logic             i_a_req,
  input  logic             i_b_req,
  input  owner_e           i_owner,
  input  logic [CNT_W-1:0] i_burst_cnt,
`ifdef ARB_ROUND_ROBIN_EN
  input  port_sel_e        i_last_winner,
`endif
  output port_sel_e        o_sel
);

  logic w_burst_left;
  logic w_keep_a;
  logic w_keep_b;

  assign w_burst_left = (i_burst_cnt < CNT_W'(MAX_BURST));

  // The owner keeps the bus while it still has burst budget or nobody else wants it.
  assign w_keep_a = (i_owner == OWN_A) && i_a_req && (w_burst_left || !i_b_req);
  assign w_keep_b = (i_owner == OWN_B) && i_b_req && (w_burst_left || !i_a_req);

  // Ownership first, then a lone requester, then the tie-break policy.
  always_comb begin
    o_sel = SEL_NONE;
    if (w_keep_a) begin
      o_sel = SEL_A;
    end else if (w_keep_b) begin
      o_sel = SEL_B;
    end else if (i_a_req && !i_b_req) begin
      o_sel = SEL_A;
    end else if (i_b_req && !i_a_req) begin
      o_sel = SEL_B;
    end else if (i_a_req && i_b_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      o_sel = (i_last_winner == SEL_A) ? SEL_B : SEL_A;
`else
      // An owner that exhausted its burst must hand over, otherwise A wins.
      o_sel = (i_owner == OWN_A) ? SEL_B : SEL_A;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_512x32_port_arbiter.sv
// ============================================================================
//  Module   : ram_512x32_port_arbiter
//  Purpose  : Shares one synchronous-read 512x32 RAM between two requesters,
//             one access per cycle, burst-bounded ownership, per-port rvalid.
//  Config   : ARB_ROUND_ROBIN_EN selects round-robin tie-break (default A wins).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_512x32_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = C_ADDR_W,
  parameter int DATA_W    = C_DATA_W,
  parameter int MAX_BURST = C_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_a_req,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  input  logic              i_b_req,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic              o_a_gnt,
  output logic              o_b_gnt,
  output logic              o_a_rvalid,
  output logic              o_b_rvalid,
  output logic [DATA_W-1:0] o_a_rdata,
  output logic [DATA_W-1:0] o_b_rdata,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_din,
  input  logic [DATA_W-1:0] i_ram_dout
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  owner_e           r_owner;
  logic [CNT_W-1:0] r_burst_cnt;
  port_sel_e        r_last_winner;
  logic             r_a_rvalid;
  logic             r_b_rvalid;

  owner_e           w_owner_nxt;
  logic [CNT_W-1:0] w_burst_cnt_nxt;
  port_sel_e        w_last_winner_nxt;
  port_sel_e        w_sel;

  ram_arb_select #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_select (
    .i_a_req       (i_a_req),
    .i_b_req       (i_b_req),
    .i_owner       (r_owner),
    .i_burst_cnt   (r_burst_cnt),
`ifdef ARB_ROUND_ROBIN_EN
    .i_last_winner (r_last_winner),
`endif
    .o_sel         (w_sel)
  );

  // Ownership state register; last_winner resets to B so A takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner       <= IDLE;
      r_burst_cnt   <= '0;
      r_last_winner <= SEL_B;
    end else begin
      r_owner       <= w_owner_nxt;
      r_burst_cnt   <= w_burst_cnt_nxt;
      r_last_winner <= w_last_winner_nxt;
    end
  end

  // Next ownership: drop to idle, extend the current burst, or hand over.
  always_comb begin
    w_owner_nxt       = r_owner;
    w_burst_cnt_nxt   = r_burst_cnt;
    w_last_winner_nxt = r_last_winner;
    if (w_sel == SEL_NONE) begin
      w_owner_nxt     = IDLE;
      w_burst_cnt_nxt = '0;
    end else if (sel_to_owner(w_sel) == r_owner) begin
      if (r_burst_cnt != CNT_W'(MAX_BURST)) begin
        w_burst_cnt_nxt = r_burst_cnt + 1'b1;
      end
    end else begin
      w_owner_nxt       = sel_to_owner(w_sel);
      w_burst_cnt_nxt   = CNT_W'(1);
      w_last_winner_nxt = w_sel;
    end
  end

  // RAM request mux; an idle cycle drives everything to zero.
  always_comb begin
    o_ram_we   = 1'b0;
    o_ram_addr = '0;
    o_ram_din  = '0;
    case (w_sel)
      SEL_A: begin
        o_ram_we   = i_a_we;
        o_ram_addr = i_a_addr;
        o_ram_din  = i_a_wdata;
      end
      SEL_B: begin
        o_ram_we   = i_b_we;
        o_ram_addr = i_b_addr;
        o_ram_din  = i_b_wdata;
      end
      default: begin
        o_ram_we   = 1'b0;
      end
    endcase
  end

  assign o_a_gnt  = (w_sel == SEL_A);
  assign o_b_gnt  = (w_sel == SEL_B);
  assign o_ram_en = o_a_gnt | o_b_gnt;

  // Read-valid pipeline matching the RAM's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_a_rvalid <= o_a_gnt & ~i_a_we;
      r_b_rvalid <= o_b_gnt & ~i_b_we;
    end
  end

  assign o_a_rvalid = r_a_rvalid;
  assign o_b_rvalid = r_b_rvalid;
  assign o_a_rdata  = i_ram_dout;
  assign o_b_rdata  = i_ram_dout;

endmodule

`default_nettype wire

// File: tb/tb_ram_512x32_port_arbiter.sv
// ============================================================================
//  Module   : tb_ram_512x32_port_arbiter
//  Purpose  : Directed self-checking bench for ram_512x32_port_arbiter with a
//             behavioural synchronous-read RAM attached.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_512x32_port_arbiter;
  import ram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, a_we, b_req, b_we;
  logic [8:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        ram_en, ram_we;
  logic [8:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = 32'h0;
  logic [31:0] mem [512];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_512x32_port_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_a_req    (a_req),
    .i_a_we     (a_we),
    .i_a_addr   (a_addr),
    .i_a_wdata  (a_wdata),
    .i_b_req    (b_req),
    .i_b_we     (b_we),
    .i_b_addr   (b_addr),
    .i_b_wdata  (b_wdata),
    .o_a_gnt    (a_gnt),
    .o_b_gnt    (b_gnt),
    .o_a_rvalid (a_rvalid),
    .o_b_rvalid (b_rvalid),
    .o_a_rdata  (a_rdata),
    .o_b_rdata  (b_rdata),
    .o_ram_en   (ram_en),
    .o_ram_we   (ram_we),
    .o_ram_addr (ram_addr),
    .o_ram_din  (ram_din),
    .i_ram_dout (ram_dout)
  );

  // Single-port synchronous RAM: writes land on the edge, reads return next cycle.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout      <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_gnt;
  logic       tie_a;

  initial begin
    for (int k = 0; k < 512; k++) mem[k] = 32'hA5A50000 | 32'(k);
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;

    // Reset state
    chk("rst_owner",  32'(dut.r_owner), 32'(IDLE));
    chk("rst_cnt",    32'(dut.r_burst_cnt), 32'd0);
    chk("rst_gnt",    {30'd0, a_gnt, b_gnt}, 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);

    // Continuous contention from idle: AAAA BBBB AAAA in either tie policy
    next_cycle();
    a_req = 1; a_we = 0; a_addr = 9'd10;
    b_req = 1; b_we = 0; b_addr = 9'd20;
    for (int i = 0; i < 12; i++) begin
      exp_gnt = (i >= 4 && i < 8) ? 2'b01 : 2'b10;
      #1;
      chk($sformatf("burst_gnt[%0d]", i), {30'd0, a_gnt, b_gnt}, {30'd0, exp_gnt});
      next_cycle();
      chk($sformatf("burst_rv[%0d]", i), {30'd0, a_rvalid, b_rvalid}, {30'd0, exp_gnt});
      if (exp_gnt[1]) chk($sformatf("burst_ad[%0d]", i), a_rdata, 32'hA5A5000A);
      else            chk($sformatf("burst_bd[%0d]", i), b_rdata, 32'hA5A50014);
    end
    a_req = 0; b_req = 0;
    next_cycle();

    // A alone: write 0xDEADBEEF to addr 5, read it back next cycle
    a_req = 1; a_we = 1; a_addr = 9'd5; a_wdata = 32'hDEADBEEF;
    #1;
    chk("wr_a_gnt", 32'(a_gnt), 32'd1);
    chk("wr_b_gnt", 32'(b_gnt), 32'd0);
    chk("wr_ram",   {ram_en, ram_we, 21'd0, ram_addr}, {1'b1, 1'b1, 21'd0, 9'd5});
    chk("wr_din",   ram_din, 32'hDEADBEEF);
    next_cycle();
    a_we = 0;
    #1;
    chk("rd_a_gnt", 32'(a_gnt), 32'd1);
    chk("rd_ram_we", 32'(ram_we), 32'd0);
    chk("wr_no_rv", 32'(a_rvalid), 32'd0);
    next_cycle();
    a_req = 0;
    chk("rd_a_rv",   32'(a_rvalid), 32'd1);
    chk("rd_a_data", a_rdata, 32'hDEADBEEF);
    chk("rd_b_rv",   32'(b_rvalid), 32'd0);
    next_cycle();

    // Tie from idle after A was the last winner
`ifdef ARB_ROUND_ROBIN_EN
    tie_a = 1'b0;
`else
    tie_a = 1'b1;
`endif
    a_req = 1; a_we = 0; a_addr = 9'd10;
    b_req = 1; b_we = 0; b_addr = 9'd20;
    #1;
    chk("tie_gnt", {30'd0, a_gnt, b_gnt}, {30'd0, tie_a, ~tie_a});
    next_cycle();
    a_req = 0; b_req = 0;
    chk("tie_rv", {30'd0, a_rvalid, b_rvalid}, {30'd0, tie_a, ~tie_a});
    next_cycle();

    // Mixed traffic: B writes addr 300, A reads it back
    b_req = 1; b_we = 1; b_addr = 9'd300; b_wdata = 32'h00001234;
    #1;
    chk("mix_b_gnt", 32'(b_gnt), 32'd1);
    next_cycle();
    b_req = 0; b_we = 0;
    a_req = 1; a_we = 0; a_addr = 9'd300;
    #1;
    chk("mix_a_gnt", 32'(a_gnt), 32'd1);
    chk("mix_b_rv0", 32'(b_rvalid), 32'd0);
    next_cycle();
    a_req = 0;
    chk("mix_a_rv",   32'(a_rvalid), 32'd1);
    chk("mix_a_data", a_rdata, 32'h00001234);
    chk("mix_b_rv1",  32'(b_rvalid), 32'd0);
    next_cycle();

    // Asynchronous reset while B's read is being granted
    b_req = 1; b_we = 0; b_addr = 9'd7;
    #1;
    chk("rst_b_gnt", 32'(b_gnt), 32'd1);
    rst_n = 1'b0; b_req = 0;
    #1;
    chk("arst_owner", 32'(dut.r_owner), 32'(IDLE));
    chk("arst_cnt",   32'(dut.r_burst_cnt), 32'd0);
    chk("arst_b_rv",  32'(b_rvalid), 32'd0);
    next_cycle();
    chk("arst_b_rv2", 32'(b_rvalid), 32'd0);
    rst_n = 1'b1;
    next_cycle();
    chk("arst_b_rv3", 32'(b_rvalid), 32'd0);
    a_req = 1; a_we = 0; a_addr = 9'd5;
    b_req = 1; b_we = 0; b_addr = 9'd7;
    #1;
    chk("arst_tie", {30'd0, a_gnt, b_gnt}, 32'd2);
    next_cycle();
    a_req = 0; b_req = 0;
    next_cycle();

    // Idle bus for 10 cycles, then a single-cycle A request
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("idle_en[%0d]", i), 32'(ram_en), 32'd0);
      next_cycle();
    end
    chk("idle_cnt",   32'(dut.r_burst_cnt), 32'd0);
    chk("idle_owner", 32'(dut.r_owner), 32'(IDLE));
    a_req = 1; a_we = 0; a_addr = 9'd5;
    #1;
    chk("post_idle_gnt", {30'd0, a_gnt, ram_en}, 32'd3);
    next_cycle();
    a_req = 0;
    chk("post_idle_rv",   32'(a_rvalid), 32'd1);
    chk("post_idle_data", a_rdata, 32'hDEADBEEF);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
